cve2_mem_arbiter: RTL and testbench
===================================

# cve2_mem_arbiter

Two-requester memory arbiter placed between the cve2 core and the SoC memory fabric. It merges the instruction-fetch port and the LSU data port onto one OBI-style host port. It tracks outstanding transactions in a small in-order ID queue and routes each response back to the requester that issued it. This lets a single-ported memory or bus slave serve the whole core.

## Interface
Parameters:
- MaxOutstanding, 2: host transactions in flight (1..4); depth of the response-ID queue.
- AddrWidth, 32: address width.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- instr_req_i / instr_gnt_o / instr_rvalid_o  in/out/out  1  instruction port handshake.
- instr_addr_i  in  AddrWidth  fetch address.
- instr_rdata_o / instr_err_o  out  32/1  fetch response.
- data_req_i / data_gnt_o / data_rvalid_o  in/out/out  1  LSU port handshake.
- data_addr_i  in  AddrWidth; data_we_i  in  1; data_be_i  in  4; data_wdata_i  in  32.
- data_rdata_o / data_err_o  out  32/1  LSU response.
- host_req_o  out  1; host_gnt_i  in  1; host_rvalid_i  in  1.
- host_addr_o  out  AddrWidth; host_we_o  out  1; host_be_o  out  4; host_wdata_o  out  32.
- host_rdata_i  in  32; host_err_i  in  1.
- unexp_rvalid_o  out  1  pulse: host_rvalid_i arrived while the ID queue was empty.

## Operation
- Arbiter FSM states: IDLE (no pending address phase) and LOCKED (owner register valid).
- Address phase in IDLE:
  - Select a requester. Fixed priority is data over instr; see Configuration for the alternative.
  - Drive host_req_o and the host address, we, be and wdata from the selected port.
  - host_gnt_i is returned combinationally to the selected port only.
- For instruction selection: host_we_o=0, host_be_o=4'hF, host_wdata_o=0.
- IDLE -> LOCKED: host_req_o=1 and host_gnt_i=0. The owner register captures the selected requester.
- LOCKED behaviour:
  - Selection is forced to the owner, whatever the other port requests.
  - LOCKED -> IDLE on host_gnt_i=1.
  - LOCKED -> IDLE also if the owner drops req. This is a protocol violation; no grant is issued that cycle.
- On each handshake (host_req_o & host_gnt_i), push the owner ID (0=instr, 1=data) into the ID queue.
- Outstanding count cnt is in 0..MaxOutstanding:
  - +1 on handshake.
  - -1 on host_rvalid_i with a non-empty queue.
  - Unchanged when both occur in the same cycle.
- Full (cnt==MaxOutstanding):
  - host_req_o=0 and both gnt=0.
  - LOCKED state is held.
  - A same-cycle rvalid does not unblock that cycle. There is no combinational rvalid->req path.
- Response phase:
  - host_rvalid_i pops the queue head.
  - rvalid, rdata and err are routed combinationally to the head-ID port.
  - The other port sees rvalid=0, and its rdata is driven with host_rdata_i (don't-care).
- host_rvalid_i with an empty queue is dropped: no port rvalid, unexp_rvalid_o=1 for that cycle, cnt stays 0.

## Timing
- Zero-cycle arbitration: port req to host_req_o is combinational, and host_gnt_i to port gnt is combinational.
- Response latency through the block is 0 cycles.
- Back-to-back grants are allowed on consecutive cycles up to MaxOutstanding.
- While rst_i=1 the following are forced to 0: host_req_o, instr_gnt_o, data_gnt_o, instr_rvalid_o, data_rvalid_o, unexp_rvalid_o.
- On the cycle after reset: state=IDLE, cnt=0, queue empty, round-robin pointer=instr (last-granted=data).
- Reset mid-operation discards all queued IDs. Responses arriving afterwards are treated as unexpected.
- If both requesters assert req in the same cycle as host_rvalid_i, the grant and the response are both processed in that cycle.

## Configuration
- CVE2_ARB_RR_EN defined:
  - Round-robin between the two ports. A last-granted register updates on each handshake.
  - On a simultaneous request, the port not granted last wins.
- CVE2_ARB_RR_EN undefined:
  - Fixed priority, data before instr.
  - No pointer register is built.
- Locking, queue and full behaviour are identical in both builds.

## Test plan
- Single fetch: instr_req_i=1, addr 0x100, gnt immediate, rvalid 2 cycles later with rdata 0xDEADBEEF. Required: instr_gnt_o=1 on the request cycle; instr_rvalid_o=1 with rdata 0xDEADBEEF; data_rvalid_o=0.
- Contention: both ports request at the same time, gnt always high. Required:
  - Fixed build: data granted first, instr next cycle.
  - RR build: instr granted first after reset (last-granted=data), then data, then alternating.
- Lock: data requests, host_gnt_i=0 for 3 cycles, instr requests in cycle 2. Required: host_addr_o stays at the data address until the grant; instr is granted only afterwards.
- Full: MaxOutstanding=2, three grants attempted with no rvalid. Required: third request sees gnt=0 and host_req_o=0 until one rvalid arrives; it is granted on the following cycle.
- Ordering: grant instr then data, then return rvalid with rdata 0x11 and 0x22. Required: 0x11 goes to instr, 0x22 to data; cnt returns to 0.
- Reset/unexpected: rst_i pulsed with 2 outstanding, then host_rvalid_i=1. Required: unexp_rvalid_o=1 for one cycle, no port rvalid, cnt=0.

Source files
------------

// File: rtl/cve2_mem_arbiter.sv
// Two-port (instruction fetch / LSU) to single OBI host arbiter with an in-order response-ID queue.
// Optional round-robin arbitration is enabled by defining CVE2_ARB_RR_EN.
module cve2_mem_arbiter #(
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned AddrWidth      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,

  input  logic                 instr_req_i,
  output logic                 instr_gnt_o,
  output logic                 instr_rvalid_o,
  input  logic [AddrWidth-1:0] instr_addr_i,
  output logic [31:0]          instr_rdata_o,
  output logic                 instr_err_o,

  input  logic                 data_req_i,
  output logic                 data_gnt_o,
  output logic                 data_rvalid_o,
  input  logic [AddrWidth-1:0] data_addr_i,
  input  logic                 data_we_i,
  input  logic [3:0]           data_be_i,
  input  logic [31:0]          data_wdata_i,
  output logic [31:0]          data_rdata_o,
  output logic                 data_err_o,

  output logic                 host_req_o,
  input  logic                 host_gnt_i,
  input  logic                 host_rvalid_i,
  output logic [AddrWidth-1:0] host_addr_o,
  output logic                 host_we_o,
  output logic [3:0]           host_be_o,
  output logic [31:0]          host_wdata_o,
  input  logic [31:0]          host_rdata_i,
  input  logic                 host_err_i,

  output logic                 unexp_rvalid_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e                    state;
  state_e                    state_next;
  logic                      owner;
  logic [CntW-1:0]           cnt;
  logic [MaxOutstanding-1:0] id_q;
  logic [MaxOutstanding-1:0] id_next;
  logic [CntW-1:0]           wr_idx;

  logic sel;          // 0 = instr, 1 = data
  logic sel_req;
  logic prio_pick;    // winner when both ports request in IDLE
  logic full;
  logic req_out;
  logic handshake;
  logic pop;
  logic head;

`ifdef CVE2_ARB_RR_EN
  logic last_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_data <= 1'b1;
    end else if (handshake) begin
      last_data <= sel;
    end
  end

  assign prio_pick = ~last_data;
`else
  assign prio_pick = 1'b1;
`endif

  assign full      = (cnt == CntW'(MaxOutstanding));
  assign sel_req   = sel ? data_req_i : instr_req_i;
  // Full blocks the request with no dependence on a same-cycle rvalid.
  assign req_out   = ~rst_i & ~full & sel_req;
  assign handshake = req_out & host_gnt_i;
  assign pop       = host_rvalid_i & (cnt != CntW'(0));
  assign head      = id_q[0];

  always_comb begin
    sel = 1'b0;
    if (state == LOCKED) begin
      sel = owner;
    end else if (data_req_i && instr_req_i) begin
      sel = prio_pick;
    end else begin
      sel = data_req_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      owner <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == LOCKED) begin
        owner <= sel;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_out && !host_gnt_i) begin
          state_next = LOCKED;
        end else begin
          state_next = IDLE;
        end
      end
      LOCKED: begin
        if (full) begin
          state_next = LOCKED;
        end else if (!sel_req || host_gnt_i) begin
          state_next = IDLE;
        end else begin
          state_next = LOCKED;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    host_req_o     = req_out;
    instr_gnt_o    = handshake & ~sel;
    data_gnt_o     = handshake & sel;
    host_addr_o    = instr_addr_i;
    host_we_o      = 1'b0;
    host_be_o      = 4'hF;
    host_wdata_o   = 32'h0;
    if (sel) begin
      host_addr_o  = data_addr_i;
      host_we_o    = data_we_i;
      host_be_o    = data_be_i;
      host_wdata_o = data_wdata_i;
    end else begin
      host_addr_o  = instr_addr_i;
    end
    instr_rvalid_o = ~rst_i & pop & ~head;
    data_rvalid_o  = ~rst_i & pop & head;
    instr_rdata_o  = host_rdata_i;
    data_rdata_o   = host_rdata_i;
    instr_err_o    = instr_rvalid_o & host_err_i;
    data_err_o     = data_rvalid_o & host_err_i;
    unexp_rvalid_o = ~rst_i & host_rvalid_i & (cnt == CntW'(0));
  end

  // Head sits at bit 0; a pop shifts the queue down before the new ID is placed.
  always_comb begin
    id_next = pop ? (id_q >> 1) : id_q;
    wr_idx  = pop ? (cnt - CntW'(1)) : cnt;
    for (int i = 0; i < int'(MaxOutstanding); i++) begin
      if (handshake && wr_idx == CntW'(i)) begin
        id_next[i] = sel;
      end else begin
        id_next[i] = id_next[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt  <= '0;
      id_q <= '0;
    end else begin
      id_q <= id_next;
      case ({handshake, pop})
        2'b10:   cnt <= cnt + CntW'(1);
        2'b01:   cnt <= cnt - CntW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_cve2_mem_arbiter.sv
// Self-checking bench for cve2_mem_arbiter: directed scenarios plus a randomized run
// against a queue-based transaction model.
module tb_cve2_mem_arbiter;

  localparam int MAX = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_req_i, instr_gnt_o, instr_rvalid_o, instr_err_o;
  logic [31:0] instr_addr_i, instr_rdata_o;
  logic        data_req_i, data_gnt_o, data_rvalid_o, data_we_i, data_err_o;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic [3:0]  data_be_i;
  logic        host_req_o, host_gnt_i, host_rvalid_i, host_we_o, host_err_i;
  logic [31:0] host_addr_o, host_wdata_o, host_rdata_i;
  logic [3:0]  host_be_o;
  logic        unexp_rvalid_o;

  int checks = 0;
  int failures = 0;

  cve2_mem_arbiter #(.MaxOutstanding(MAX), .AddrWidth(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o), .instr_err_o(instr_err_o),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_addr_i(data_addr_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .host_req_o(host_req_o), .host_gnt_i(host_gnt_i), .host_rvalid_i(host_rvalid_i),
    .host_addr_o(host_addr_o), .host_we_o(host_we_o), .host_be_o(host_be_o),
    .host_wdata_o(host_wdata_o), .host_rdata_i(host_rdata_i), .host_err_i(host_err_i),
    .unexp_rvalid_o(unexp_rvalid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    instr_req_i = 1'b0; instr_addr_i = 32'h0;
    data_req_i = 1'b0; data_addr_i = 32'h0; data_we_i = 1'b0; data_be_i = 4'h0; data_wdata_i = 32'h0;
    host_gnt_i = 1'b0; host_rvalid_i = 1'b0; host_rdata_i = 32'h0; host_err_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    instr_req_i = 1'b1; data_req_i = 1'b1; host_gnt_i = 1'b1; host_rvalid_i = 1'b1;
    #4;
    checks++; if ({host_req_o, instr_gnt_o, data_gnt_o} !== 3'b000) begin failures++; $display("FAIL reset_req_gnt got=%b exp=000", {host_req_o, instr_gnt_o, data_gnt_o}); end
    checks++; if ({instr_rvalid_o, data_rvalid_o, unexp_rvalid_o} !== 3'b000) begin failures++; $display("FAIL reset_rvalid got=%b exp=000", {instr_rvalid_o, data_rvalid_o, unexp_rvalid_o}); end
    step();
    idle_inputs(); rst_i = 1'b0; host_rvalid_i = 1'b1;
    #4;
    checks++; if (unexp_rvalid_o !== 1'b1) begin failures++; $display("FAIL reset_empty_unexp got=%b exp=1", unexp_rvalid_o); end
    checks++; if ({instr_rvalid_o, data_rvalid_o, host_req_o} !== 3'b000) begin failures++; $display("FAIL reset_empty_rvalid got=%b exp=000", {instr_rvalid_o, data_rvalid_o, host_req_o}); end
  endtask

  task automatic test_single_fetch();
    do_reset();
    step();
    instr_req_i = 1'b1; instr_addr_i = 32'h100; host_gnt_i = 1'b1;
    #4;
    checks++; if ({instr_gnt_o, data_gnt_o} !== 2'b10) begin failures++; $display("FAIL fetch_gnt got=%b exp=10", {instr_gnt_o, data_gnt_o}); end
    checks++; if ({host_addr_o, host_we_o, host_be_o, host_wdata_o} !== {32'h100, 1'b0, 4'hF, 32'h0}) begin failures++; $display("FAIL fetch_addr_phase got=%h/%b/%h/%h exp=100/0/f/0", host_addr_o, host_we_o, host_be_o, host_wdata_o); end
    step();
    idle_inputs();
    step();
    host_rvalid_i = 1'b1; host_rdata_i = 32'hDEADBEEF;
    #4;
    checks++; if ({instr_rvalid_o, data_rvalid_o} !== 2'b10) begin failures++; $display("FAIL fetch_rvalid got=%b exp=10", {instr_rvalid_o, data_rvalid_o}); end
    checks++; if (instr_rdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL fetch_rdata got=%h exp=deadbeef", instr_rdata_o); end
  endtask

  task automatic test_contention();
    logic first;
`ifdef CVE2_ARB_RR_EN
    first = 1'b0;
`else
    first = 1'b1;
`endif
    do_reset();
    step();
    instr_req_i = 1'b1; instr_addr_i = 32'h200; data_req_i = 1'b1; data_addr_i = 32'h300; host_gnt_i = 1'b1;
    #4;
    checks++; if ({data_gnt_o, instr_gnt_o} !== {first, ~first}) begin failures++; $display("FAIL contention_first got=%b exp=%b", {data_gnt_o, instr_gnt_o}, {first, ~first}); end
    checks++; if (host_addr_o !== (first ? 32'h300 : 32'h200)) begin failures++; $display("FAIL contention_addr got=%h exp=%h", host_addr_o, first ? 32'h300 : 32'h200); end
    step();
    if (first) data_req_i = 1'b0; else instr_req_i = 1'b0;
    #4;
    checks++; if ({data_gnt_o, instr_gnt_o} !== {~first, first}) begin failures++; $display("FAIL contention_second got=%b exp=%b", {data_gnt_o, instr_gnt_o}, {~first, first}); end
    step();
    idle_inputs(); host_rvalid_i = 1'b1; host_rdata_i = 32'hA;
    #4;
    checks++; if ({data_rvalid_o, instr_rvalid_o} !== {first, ~first}) begin failures++; $display("FAIL contention_resp1 got=%b exp=%b", {data_rvalid_o, instr_rvalid_o}, {first, ~first}); end
    step();
    host_rdata_i = 32'hB;
    #4;
    checks++; if ({data_rvalid_o, instr_rvalid_o} !== {~first, first}) begin failures++; $display("FAIL contention_resp2 got=%b exp=%b", {data_rvalid_o, instr_rvalid_o}, {~first, first}); end
  endtask

  task automatic test_lock();
    do_reset();
    step();
    data_req_i = 1'b1; data_addr_i = 32'h400; data_we_i = 1'b1; data_be_i = 4'h3; data_wdata_i = 32'h55;
    #4;
    checks++; if ({host_req_o, data_gnt_o, host_addr_o} !== {1'b1, 1'b0, 32'h400}) begin failures++; $display("FAIL lock_c1 got=%b/%b/%h exp=1/0/400", host_req_o, data_gnt_o, host_addr_o); end
    for (int c = 2; c <= 3; c++) begin
      step();
      instr_req_i = 1'b1; instr_addr_i = 32'h500;
      #4;
      checks++; if ({instr_gnt_o, data_gnt_o, host_addr_o, host_wdata_o} !== {2'b00, 32'h400, 32'h55}) begin failures++; $display("FAIL lock_hold c%0d got=%b%b/%h/%h exp=00/400/55", c, instr_gnt_o, data_gnt_o, host_addr_o, host_wdata_o); end
    end
    step();
    host_gnt_i = 1'b1;
    #4;
    checks++; if ({instr_gnt_o, data_gnt_o, host_addr_o, host_we_o, host_be_o} !== {2'b01, 32'h400, 1'b1, 4'h3}) begin failures++; $display("FAIL lock_grant got=%b%b/%h/%b/%h exp=01/400/1/3", instr_gnt_o, data_gnt_o, host_addr_o, host_we_o, host_be_o); end
    step();
    data_req_i = 1'b0;
    #4;
    checks++; if ({instr_gnt_o, data_gnt_o, host_addr_o, host_we_o} !== {2'b10, 32'h500, 1'b0}) begin failures++; $display("FAIL lock_after got=%b%b/%h/%b exp=10/500/0", instr_gnt_o, data_gnt_o, host_addr_o, host_we_o); end
  endtask

  task automatic test_full();
    do_reset();
    for (int g = 0; g < MAX; g++) begin
      step();
      instr_req_i = 1'b1; instr_addr_i = 32'h600 + 32'(g); host_gnt_i = 1'b1;
      #4;
      checks++; if (instr_gnt_o !== 1'b1) begin failures++; $display("FAIL full_fill%0d got=%b exp=1", g, instr_gnt_o); end
    end
    step();
    #4;
    checks++; if ({host_req_o, instr_gnt_o} !== 2'b00) begin failures++; $display("FAIL full_block got=%b exp=00", {host_req_o, instr_gnt_o}); end
    step();
    host_rvalid_i = 1'b1;
    #4;
    checks++; if ({host_req_o, instr_gnt_o, instr_rvalid_o} !== 3'b001) begin failures++; $display("FAIL full_same_cycle got=%b exp=001", {host_req_o, instr_gnt_o, instr_rvalid_o}); end
    step();
    host_rvalid_i = 1'b0;
    #4;
    checks++; if ({host_req_o, instr_gnt_o} !== 2'b11) begin failures++; $display("FAIL full_unblock got=%b exp=11", {host_req_o, instr_gnt_o}); end
  endtask

  task automatic test_ordering();
    do_reset();
    step();
    instr_req_i = 1'b1; host_gnt_i = 1'b1;
    #4;
    checks++; if (instr_gnt_o !== 1'b1) begin failures++; $display("FAIL order_gnt_instr got=%b exp=1", instr_gnt_o); end
    step();
    instr_req_i = 1'b0; data_req_i = 1'b1;
    #4;
    checks++; if (data_gnt_o !== 1'b1) begin failures++; $display("FAIL order_gnt_data got=%b exp=1", data_gnt_o); end
    step();
    idle_inputs(); host_rvalid_i = 1'b1; host_rdata_i = 32'h11;
    #4;
    checks++; if ({instr_rvalid_o, data_rvalid_o, instr_rdata_o} !== {2'b10, 32'h11}) begin failures++; $display("FAIL order_resp1 got=%b%b/%h exp=10/11", instr_rvalid_o, data_rvalid_o, instr_rdata_o); end
    step();
    host_rdata_i = 32'h22;
    #4;
    checks++; if ({instr_rvalid_o, data_rvalid_o, data_rdata_o} !== {2'b01, 32'h22}) begin failures++; $display("FAIL order_resp2 got=%b%b/%h exp=01/22", instr_rvalid_o, data_rvalid_o, data_rdata_o); end
    step();
    host_rdata_i = 32'h33;
    #4;
    checks++; if ({unexp_rvalid_o, instr_rvalid_o, data_rvalid_o} !== 3'b100) begin failures++; $display("FAIL order_drained got=%b exp=100", {unexp_rvalid_o, instr_rvalid_o, data_rvalid_o}); end
  endtask

  task automatic test_reset_unexpected();
    do_reset();
    step();
    instr_req_i = 1'b1; host_gnt_i = 1'b1;
    step();
    instr_req_i = 1'b0; data_req_i = 1'b1;
    step();
    idle_inputs(); rst_i = 1'b1;
    step();
    rst_i = 1'b0; host_rvalid_i = 1'b1;
    #4;
    checks++; if ({unexp_rvalid_o, instr_rvalid_o, data_rvalid_o} !== 3'b100) begin failures++; $display("FAIL rstunexp_first got=%b exp=100", {unexp_rvalid_o, instr_rvalid_o, data_rvalid_o}); end
    step();
    #4;
    checks++; if ({unexp_rvalid_o, instr_rvalid_o, data_rvalid_o} !== 3'b100) begin failures++; $display("FAIL rstunexp_cnt0 got=%b exp=100", {unexp_rvalid_o, instr_rvalid_o, data_rvalid_o}); end
    step();
    host_rvalid_i = 1'b0;
    #4;
    checks++; if (unexp_rvalid_o !== 1'b0) begin failures++; $display("FAIL rstunexp_pulse got=%b exp=0", unexp_rvalid_o); end
  endtask

  // Model: queue of outstanding requester IDs plus an optional pending (ungranted) claim.
  task automatic test_random();
    int   q[$];
    bit   pend_v, pend_o, last_d, ch, want, ereq, pop, full;
    bit   eig, edg, eir, edr, eun;
    do_reset();
    pend_v = 1'b0; pend_o = 1'b0; last_d = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      step();
      rst_i         = ($urandom_range(0, 99) < 2);
      instr_req_i   = ($urandom_range(0, 99) < 55);
      data_req_i    = ($urandom_range(0, 99) < 55);
      instr_addr_i  = $urandom; data_addr_i = $urandom; data_wdata_i = $urandom;
      data_we_i     = 1'($urandom); data_be_i = 4'($urandom);
      host_gnt_i    = ($urandom_range(0, 99) < 50);
      host_rvalid_i = ($urandom_range(0, 99) < 40);
      host_rdata_i  = $urandom; host_err_i = 1'($urandom);
      #4;
      full = (q.size() >= MAX);
      if (pend_v) begin
        ch = pend_o;
        want = ch ? data_req_i : instr_req_i;
      end else begin
        want = instr_req_i | data_req_i;
`ifdef CVE2_ARB_RR_EN
        ch = (instr_req_i && data_req_i) ? ~last_d : data_req_i;
`else
        ch = data_req_i;
`endif
      end
      ereq = want && !full && !rst_i;
      eig = ereq && host_gnt_i && !ch;
      edg = ereq && host_gnt_i && ch;
      pop = host_rvalid_i && q.size() > 0 && !rst_i;
      eir = pop && q[0] == 0;
      edr = pop && q[0] == 1;
      eun = host_rvalid_i && q.size() == 0 && !rst_i;
      checks++; if ({host_req_o, instr_gnt_o, data_gnt_o} !== {ereq, eig, edg}) begin failures++; $display("FAIL rnd_req_gnt n=%0d got=%b exp=%b", n, {host_req_o, instr_gnt_o, data_gnt_o}, {ereq, eig, edg}); end
      checks++; if ({instr_rvalid_o, data_rvalid_o, unexp_rvalid_o} !== {eir, edr, eun}) begin failures++; $display("FAIL rnd_rvalid n=%0d got=%b exp=%b", n, {instr_rvalid_o, data_rvalid_o, unexp_rvalid_o}, {eir, edr, eun}); end
      if (ereq) begin
        checks++;
        if ({host_addr_o, host_we_o, host_be_o, host_wdata_o} !== (ch ? {data_addr_i, data_we_i, data_be_i, data_wdata_i} : {instr_addr_i, 1'b0, 4'hF, 32'h0})) begin
          failures++; $display("FAIL rnd_addr_phase n=%0d sel=%b got=%h/%b/%h/%h", n, ch, host_addr_o, host_we_o, host_be_o, host_wdata_o);
        end
      end
      if (eir) begin
        checks++; if ({instr_rdata_o, instr_err_o} !== {host_rdata_i, host_err_i}) begin failures++; $display("FAIL rnd_instr_resp n=%0d got=%h/%b exp=%h/%b", n, instr_rdata_o, instr_err_o, host_rdata_i, host_err_i); end
      end
      if (edr) begin
        checks++; if ({data_rdata_o, data_err_o} !== {host_rdata_i, host_err_i}) begin failures++; $display("FAIL rnd_data_resp n=%0d got=%h/%b exp=%h/%b", n, data_rdata_o, data_err_o, host_rdata_i, host_err_i); end
      end
      if (rst_i) begin
        q.delete(); pend_v = 1'b0; last_d = 1'b1;
      end else begin
        if (pop) void'(q.pop_front());
        if (ereq && host_gnt_i) begin
          q.push_back(int'(ch));
          last_d = ch;
        end
        if (!full) begin
          if (pend_v) begin
            if (!want || host_gnt_i) pend_v = 1'b0;
          end else if (ereq && !host_gnt_i) begin
            pend_v = 1'b1; pend_o = ch;
          end
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    test_reset();
    test_single_fetch();
    test_contention();
    test_lock();
    test_full();
    test_ordering();
    test_reset_unexpected();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
